// File: rtl/div_block_streamer_pkg.sv
// div_block_streamer_pkg: shared FSM states, default geometry and block-count derivation
package div_block_streamer_pkg;
  localparam int N_DEF = 4096;
  localparam int M_DEF = 2048;
  localparam int BLOCK_DEF = 128;
  typedef enum logic [2:0] {IDLE, START, SEND, GAP, WAIT, RECV} state_t;
  // NCNT = blocks(N, BLOCK), MCNT = blocks(M, BLOCK)
  function automatic int blocks(input int bits, input int block);
    return bits / block;
  endfunction
endpackage

// File: rtl/div_block_collector.sv
// div_block_collector: gathers result blocks into quotient/remainder, LS block first
// Ports: clk, rst (async, active-high); clr restarts the block index for a new job;
//   en marks the states where results are accepted; data_vld_out/qblock/rblock is the
//   divider result stream; quotient/remainder hold the assembled result;
//   cap flags a block captured this cycle, last flags the final block of the job.
module div_block_collector
  import div_block_streamer_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int BLOCK = BLOCK_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             data_vld_out,
  input  logic [BLOCK-1:0] qblock,
  input  logic [BLOCK-1:0] rblock,
  output logic [N-1:0]     quotient,
  output logic [N-1:0]     remainder,
  output logic             cap,
  output logic             last
);
  localparam int NCNT = blocks(N, BLOCK);
  localparam int JW = $clog2(NCNT + 1);
  logic [JW-1:0] j;
  assign cap = en && data_vld_out;
  assign last = cap && j == JW'(NCNT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      j <= '0;
      quotient <= '0;
      remainder <= '0;
    end else if (clr) begin
      j <= '0;
    end else if (cap) begin
      quotient[j*BLOCK +: BLOCK] <= qblock;
      remainder[j*BLOCK +: BLOCK] <= rblock;
      j <= last ? '0 : j + 1'b1;
    end
endmodule

// File: rtl/div_block_streamer.sv
// div_block_streamer: streams wide operands to a block divider and reassembles its results
// Ports: clk, rst (async, active-high); start/ready job handshake (ready only in IDLE);
//   dividend/divisor latched on acceptance; valid_in (one-cycle job marker),
//   data_vld_in, x, y operand stream, LS block first; qblock, rblock, data_vld_out
//   result stream; quotient/remainder assembled result; done one-cycle completion pulse.
// Option: define DIV_STREAM_TIMEOUT_EN to add parameter TIMEOUT and output timeout,
//   which abandon a job after TIMEOUT result-less cycles in WAIT/RECV.
module div_block_streamer
  import div_block_streamer_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int M = M_DEF,
  parameter int BLOCK = BLOCK_DEF
`ifdef DIV_STREAM_TIMEOUT_EN
  , parameter int TIMEOUT = 65535
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  input  logic [N-1:0]     dividend,
  input  logic [M-1:0]     divisor,
  output logic             valid_in,
  output logic             data_vld_in,
  output logic [BLOCK-1:0] x,
  output logic [BLOCK-1:0] y,
  input  logic [BLOCK-1:0] qblock,
  input  logic [BLOCK-1:0] rblock,
  input  logic             data_vld_out,
  output logic [N-1:0]     quotient,
  output logic [N-1:0]     remainder,
  output logic             done
`ifdef DIV_STREAM_TIMEOUT_EN
  , output logic           timeout
`endif
);
  localparam int NCNT = blocks(N, BLOCK);
  localparam int KW = $clog2(NCNT + 1);
  state_t state, state_n;
  logic [N-1:0] dvd_r, dvs_ext;
  logic [M-1:0] dvs_r;
  logic [KW-1:0] k, k_n;
  logic accept, collect, cap, last, expire;
  assign ready = state == IDLE;
  assign accept = ready && start;
  assign collect = state == WAIT || state == RECV;
  // Zero-extending the divisor makes every block at or above MCNT read as zero.
  assign dvs_ext = N'(dvs_r);
`ifdef DIV_STREAM_TIMEOUT_EN
  logic [15:0] tcnt;
  assign expire = collect && !cap && tcnt == 16'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tcnt <= '0;
      timeout <= 1'b0;
    end else begin
      tcnt <= collect && !cap && !expire ? tcnt + 1'b1 : '0;
      timeout <= expire;
    end
`else
  assign expire = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = start ? START : IDLE;
      START: state_n = SEND;
      SEND: state_n = k == KW'(NCNT - 1) ? GAP : SEND;
      GAP: state_n = WAIT;
      WAIT, RECV: state_n = last || expire ? IDLE : cap ? RECV : state;
      default: state_n = IDLE;
    endcase
    // k_n is the block presented in the next cycle; outputs below are registered from it.
    k_n = state == SEND ? k + 1'b1 : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      k <= '0;
      dvd_r <= '0;
      dvs_r <= '0;
      valid_in <= 1'b0;
      data_vld_in <= 1'b0;
      x <= '0;
      y <= '0;
      done <= 1'b0;
    end else begin
      k <= k_n;
      if (accept) begin
        dvd_r <= dividend;
        dvs_r <= divisor;
      end
      valid_in <= state_n == START;
      data_vld_in <= state_n == SEND;
      x <= state_n == SEND ? dvd_r[k_n*BLOCK +: BLOCK] : '0;
      y <= state_n == SEND ? dvs_ext[k_n*BLOCK +: BLOCK] : '0;
      done <= last;
    end
  div_block_collector #(.N(N), .BLOCK(BLOCK)) u_collect (
    .clk(clk),
    .rst(rst),
    .clr(accept),
    .en(collect),
    .data_vld_out(data_vld_out),
    .qblock(qblock),
    .rblock(rblock),
    .quotient(quotient),
    .remainder(remainder),
    .cap(cap),
    .last(last)
  );
endmodule

// File: tb/tb_div_block_streamer.sv
// tb_div_block_streamer: directed self-checking bench for div_block_streamer (default geometry)
module tb_div_block_streamer;
  logic clk = 1'b0;
  logic rst, start, valid_in, data_vld_in, data_vld_out, done, ready;
  logic [4095:0] dividend, quotient, remainder;
  logic [2047:0] divisor;
  logic [127:0] x, y, qblock, rblock;
`ifdef DIV_STREAM_TIMEOUT_EN
  logic timeout;
`endif
  int checks = 0;
  int errors = 0;
  int vin_cnt, dv_cnt, done_cnt, to_cnt;
  logic mon_clr;
  logic [127:0] xs [32];
  logic [127:0] ys [32];
  logic [4095:0] dvd_acc, dvs_acc;

  always #5 clk = ~clk;

  div_block_streamer #(.N(4096), .M(2048), .BLOCK(128)
`ifdef DIV_STREAM_TIMEOUT_EN
    , .TIMEOUT(100)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .ready(ready),
    .dividend(dividend),
    .divisor(divisor),
    .valid_in(valid_in),
    .data_vld_in(data_vld_in),
    .x(x),
    .y(y),
    .qblock(qblock),
    .rblock(rblock),
    .data_vld_out(data_vld_out),
    .quotient(quotient),
    .remainder(remainder),
    .done(done)
`ifdef DIV_STREAM_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );

  always @(negedge clk) begin
    if (mon_clr) begin
      vin_cnt = 0;
      dv_cnt = 0;
      done_cnt = 0;
      to_cnt = 0;
      dvd_acc = '0;
      dvs_acc = '0;
    end else begin
      if (valid_in) vin_cnt++;
      if (data_vld_in && dv_cnt < 32) begin
        xs[dv_cnt] = x;
        ys[dv_cnt] = y;
        dvd_acc[dv_cnt*128 +: 128] = x;
        dvs_acc[dv_cnt*128 +: 128] = y;
      end
      if (data_vld_in) dv_cnt++;
      if (done) done_cnt++;
`ifdef DIV_STREAM_TIMEOUT_EN
      if (timeout) to_cnt++;
`endif
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(posedge clk); #1;
    mon_clr = 1'b0;
  endtask

  task automatic run_send(input logic gap_junk);
    int t = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (dv_cnt < 32 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("send_bound", 128'(t < 200), 128'd1);
    if (gap_junk) begin
      data_vld_out = 1'b1;
      qblock = '1;
      rblock = '1;
    end
    @(posedge clk); #1;
    data_vld_out = 1'b0;
    qblock = '0;
    rblock = '0;
  endtask

  task automatic send_results(input logic [4095:0] q, input logic [4095:0] r,
                              input int hole_at, input int hole_len, input int extra);
    for (int j = 0; j < 32; j++) begin
      if (j == hole_at) begin
        data_vld_out = 1'b0;
        repeat (hole_len) begin
          @(posedge clk); #1;
        end
      end
      data_vld_out = 1'b1;
      qblock = q[j*128 +: 128];
      rblock = r[j*128 +: 128];
      @(posedge clk); #1;
    end
    for (int e = 0; e < extra; e++) begin
      qblock = '1;
      rblock = '1;
      @(posedge clk); #1;
    end
    data_vld_out = 1'b0;
    qblock = '0;
    rblock = '0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    logic [4095:0] eq, er;
    int bad, nz;
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    data_vld_out = 1'b0;
    qblock = '0;
    rblock = '0;
    mon_clr = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("rst_ready", 128'(ready), 128'd1);
    check("rst_valid_in", 128'(valid_in), 128'd0);
    check("rst_data_vld_in", 128'(data_vld_in), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_x", x, 128'd0);
    check("rst_y", y, 128'd0);
    check("rst_quotient", 128'(|quotient), 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    clear_mon();
    dividend = 4096'd100;
    divisor = 2048'd7;
    run_send(1'b1);
    send_results(dvd_acc / dvs_acc, dvd_acc % dvs_acc, -1, 0, 0);
    repeat (3) @(posedge clk); #1;
    check("div_q", quotient[127:0], 128'd14);
    check("div_q_hi", 128'(|quotient[4095:128]), 128'd0);
    check("div_r", remainder[127:0], 128'd2);
    check("div_r_hi", 128'(|remainder[4095:128]), 128'd0);
    check("div_done_cnt", 128'(done_cnt), 128'd1);
    check("div_ready", 128'(ready), 128'd1);
    check("div_vin_cnt", 128'(vin_cnt), 128'd1);
    check("div_dv_cnt", 128'(dv_cnt), 128'd32);

    clear_mon();
    dividend = 4096'd1 << 128;
    divisor = 2048'd3;
    run_send(1'b0);
    check("blk_x1", xs[1], 128'd1);
    nz = 0;
    for (int k = 0; k < 32; k++) if (k != 1 && xs[k] != 0) nz++;
    check("blk_x_others", 128'(nz), 128'd0);
    check("blk_y0", ys[0], 128'd3);
    nz = 0;
    for (int k = 1; k < 16; k++) if (ys[k] != 0) nz++;
    check("blk_y_1_15", 128'(nz), 128'd0);
    nz = 0;
    for (int k = 16; k < 32; k++) if (ys[k] != 0) nz++;
    check("blk_y_ge16", 128'(nz), 128'd0);
    send_results(dvd_acc / dvs_acc, dvd_acc % dvs_acc, -1, 0, 0);
    repeat (3) @(posedge clk); #1;
    check("blk_q", quotient[127:0], {32{4'h5}});
    check("blk_r", remainder[127:0], 128'd1);

    clear_mon();
    dividend = 4096'd12346;
    divisor = 2048'd5;
    start = 1'b1;
    repeat (40) @(posedge clk); #1;
    start = 1'b0;
    check("hold_vin_cnt", 128'(vin_cnt), 128'd1);
    check("hold_dv_cnt", 128'(dv_cnt), 128'd32);
    send_results(dvd_acc / dvs_acc, dvd_acc % dvs_acc, -1, 0, 0);
    repeat (3) @(posedge clk); #1;
    check("hold_q", quotient[127:0], 128'd2469);
    check("hold_r", remainder[127:0], 128'd1);
    check("hold_done_cnt", 128'(done_cnt), 128'd1);

    clear_mon();
    dividend = 4096'd9;
    divisor = 2048'd2;
    run_send(1'b0);
    for (int j = 0; j < 32; j++) begin
      eq[j*128 +: 128] = 128'h0A00_0000 + 128'(j);
      er[j*128 +: 128] = 128'h5500 ^ 128'(j);
    end
    send_results(eq, er, 6, 2, 3);
    repeat (3) @(posedge clk); #1;
    bad = 0;
    for (int j = 0; j < 32; j++)
      if (quotient[j*128 +: 128] !== eq[j*128 +: 128] || remainder[j*128 +: 128] !== er[j*128 +: 128]) bad++;
    check("hole_bad_blocks", 128'(bad), 128'd0);
    check("hole_q_top", quotient[4095:3968], 128'h0A00_001F);
    check("hole_r_b6", remainder[895:768], 128'h5506);
    check("hole_done_cnt", 128'(done_cnt), 128'd1);
    check("hole_ready", 128'(ready), 128'd1);

    clear_mon();
    dividend = '1;
    divisor = '1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_mid_dvin", 128'(data_vld_in), 128'd0);
    check("rst_mid_x", x, 128'd0);
    check("rst_mid_ready", 128'(ready), 128'd1);
    check("rst_mid_quot", 128'(|quotient), 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_dv_cnt", 128'(dv_cnt), 128'd9);
    clear_mon();
    dividend = 4096'd1001;
    divisor = 2048'd10;
    run_send(1'b0);
    check("rst_new_dv_cnt", 128'(dv_cnt), 128'd32);
    check("rst_new_vin_cnt", 128'(vin_cnt), 128'd1);
    send_results(dvd_acc / dvs_acc, dvd_acc % dvs_acc, -1, 0, 0);
    repeat (3) @(posedge clk); #1;
    check("rst_new_q", quotient[127:0], 128'd100);
    check("rst_new_r", remainder[127:0], 128'd1);

`ifdef DIV_STREAM_TIMEOUT_EN
    clear_mon();
    dividend = 4096'd55;
    divisor = 2048'd5;
    run_send(1'b0);
    repeat (99) @(posedge clk); #1;
    check("to_early", 128'(timeout), 128'd0);
    @(posedge clk); #1;
    check("to_pulse", 128'(timeout), 128'd1);
    check("to_done", 128'(done), 128'd0);
    check("to_ready", 128'(ready), 128'd1);
    repeat (3) @(posedge clk); #1;
    check("to_cnt", 128'(to_cnt), 128'd1);
    check("to_done_cnt", 128'(done_cnt), 128'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/div_block_streamer.md
DIV_BLOCK_STREAMER -- requirements
Module: div_block_streamer

Interface
REQ-001 SHALL have parameter N, default 4096: dividend, quotient and remainder width in bits.
REQ-002 SHALL have parameter M, default 2048: divisor width in bits.
REQ-003 SHALL have parameter BLOCK, default 128: block transfer width; N and M SHALL be multiples of BLOCK.
REQ-004 SHALL have port clk, input, 1: single clock, all logic on the rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have ports start (input, 1) and ready (output, 1): job request, and idle/accepting.
REQ-007 SHALL have ports dividend (input, N) and divisor (input, M): operands, sampled when a job is accepted.
REQ-008 SHALL have ports valid_in, data_vld_in (outputs, 1), x, y (outputs, BLOCK): divider-side operand stream.
REQ-009 SHALL have ports qblock, rblock (inputs, BLOCK) and data_vld_out (input, 1): divider-side result stream.
REQ-010 SHALL have ports quotient, remainder (outputs, N) and done (output, 1): assembled result, with a one-cycle completion pulse.

Function
REQ-011 SHALL use FSM states IDLE, START, SEND, GAP, WAIT, RECV; ready SHALL be 1 only in IDLE.
REQ-012 IDLE: start=1 SHALL latch dividend and divisor and go to START; start outside IDLE SHALL be ignored.
REQ-013 START: valid_in SHALL be 1 for exactly one cycle, with data_vld_in=0; next state SEND.
REQ-014 SEND: SHALL last exactly NCNT=N/BLOCK consecutive cycles with data_vld_in=1; block index k runs 0..NCNT-1, least-significant block first.
REQ-015 SEND: x SHALL be dividend[k*BLOCK +: BLOCK]; y SHALL be divisor[k*BLOCK +: BLOCK] for k<MCNT=M/BLOCK, else zero.
REQ-016 The first SEND cycle SHALL immediately follow the START cycle, so that the divider sees data_vld_in high on its first input cycle.
REQ-017 GAP: data_vld_in SHALL be 0 for one cycle, then go to WAIT.
REQ-018 WAIT/RECV: each cycle with data_vld_out=1 SHALL capture qblock into quotient[j*BLOCK +: BLOCK] and rblock into remainder[j*BLOCK +: BLOCK], with j counting 0..NCNT-1.
REQ-019 After capturing block j=NCNT-1, done SHALL pulse high for one cycle on the next cycle and the FSM SHALL return to IDLE.
REQ-020 data_vld_out asserted beyond NCNT blocks, or while in IDLE, SEND or GAP, SHALL be ignored.
REQ-021 A gap in data_vld_out during RECV SHALL hold j; capture resumes when data_vld_out returns high.
REQ-022 quotient and remainder SHALL hold their values until the next job overwrites them block by block.
REQ-023 valid_in, data_vld_in, x, y and done SHALL all be registered outputs.
REQ-024 Operand latency: valid_in SHALL rise 1 cycle after start is accepted; the last block SHALL be sent NCNT+1 cycles after acceptance.

Reset
REQ-025 On rst=1, the block SHALL immediately enter IDLE, including when a job is mid-operation.
REQ-026 On rst=1: valid_in, data_vld_in and done SHALL be 0; x, y, quotient, remainder and the counters SHALL be 0; ready SHALL be 1.

Configuration
REQ-027 With DIV_STREAM_TIMEOUT_EN defined, a 16-bit counter SHALL run in WAIT/RECV; if it reaches parameter TIMEOUT (default 65535) cycles without a captured block, the block SHALL return to IDLE and pulse output timeout for one cycle, with done staying 0.
REQ-028 Without DIV_STREAM_TIMEOUT_EN, the timeout port and counter SHALL be absent and WAIT SHALL be unbounded.

Structure
REQ-029 A shared package SHALL hold the FSM state enum, the default N/M/BLOCK values and the NCNT/MCNT derivation.
REQ-030 The result-capture logic (j counter, block write into quotient/remainder) SHALL be one sub-module, div_block_collector; the rest SHALL be inline.

Verification
REQ-031 Bench case: dividend=100, divisor=7, with a behavioural divider model -> quotient=14, remainder=2, one done pulse, ready returns to 1.
REQ-032 Bench case: dividend=1<<128, divisor=3 -> x=1 only at SEND k=1 and 0 elsewhere; y=3 at k=0; y=0 for all k>=16.
REQ-033 Bench case: start held high for 40 cycles -> exactly one valid_in pulse and exactly 32 data_vld_in cycles.
REQ-034 Bench case: data_vld_out high for 35 cycles with a 2-cycle hole after block 5 -> 32 blocks captured in order, done once.
REQ-035 Bench case: rst asserted in the 10th SEND cycle -> data_vld_in=0 at once; a new start then yields a full 32-block send.
REQ-036 Bench case (macro on, TIMEOUT=100): no data_vld_out -> timeout pulse 100 cycles after entering WAIT, done=0, ready=1.
